// File: rtl/bp_update_ctrl.sv
// Update controller for a 2-bit branch predictor counter table: it sweeps the
// table to INIT_VALUE, then drains queued branch outcomes as read-modify-writes.
module bp_update_ctrl #(
   parameter int          INDEX_WIDTH = 4,
   parameter int          ADDR_WIDTH  = 26,
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [1:0]  INIT_VALUE  = 2'b10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   upd_valid,
   output logic                   upd_ready,
   input  logic [ADDR_WIDTH-1:0]  upd_pc,
   input  logic                   upd_taken,
   input  logic                   flush_req,
   output logic [INDEX_WIDTH-1:0] tbl_rd_index,
   input  logic [1:0]             tbl_rd_counter,
   output logic                   tbl_we,
   output logic [INDEX_WIDTH-1:0] tbl_wr_index,
   output logic [1:0]             tbl_wr_counter,
   output logic                   pred_enable,
   output logic                   busy,
   output logic [15:0]            upd_count
);

   // Pointers wrap naturally because FIFO_DEPTH is a power of two (>= 2).
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic {S_INIT = 1'b0, S_IDLE = 1'b1} state_t;

   state_t                 state, state_nxt;
   logic [INDEX_WIDTH-1:0] sweep_idx;
   logic [INDEX_WIDTH:0]   fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]          rd_ptr, wr_ptr;
   logic [CW-1:0]          fifo_cnt;
   logic                   fifo_full, fifo_empty, push, pop;
   logic [INDEX_WIDTH-1:0] head_idx;
   logic                   head_taken;
   logic [1:0]             ctr_next;
   logic                   unused_pc_hi;

   assign unused_pc_hi = ^upd_pc[ADDR_WIDTH-1:INDEX_WIDTH];

   assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
   assign fifo_empty = (fifo_cnt == '0);
   assign head_idx   = fifo_mem[rd_ptr][INDEX_WIDTH:1];
   assign head_taken = fifo_mem[rd_ptr][0];

   // Ready depends only on registered occupancy, never on this cycle's pop.
   assign upd_ready = rst_n && !fifo_full && !flush_req;
   assign push      = upd_valid && upd_ready;
   assign pop       = (state == S_IDLE) && !fifo_empty && !flush_req;

   always_comb begin
      ctr_next = tbl_rd_counter;
      if (head_taken) begin
         if (tbl_rd_counter != 2'b11) ctr_next = tbl_rd_counter + 2'b01;
      end else begin
         if (tbl_rd_counter != 2'b00) ctr_next = tbl_rd_counter - 2'b01;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_INIT;
         sweep_idx <= '0;
      end else begin
         state     <= state_nxt;
         sweep_idx <= (flush_req || state != S_INIT) ? '0 : sweep_idx + 1'b1;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      if (flush_req)
         state_nxt = S_INIT;
      else if (state == S_INIT && sweep_idx == '1)
         state_nxt = S_IDLE;
   end

   // Output logic
   always_comb begin
      tbl_we         = 1'b0;
      tbl_wr_index   = sweep_idx;
      tbl_wr_counter = INIT_VALUE;
      tbl_rd_index   = head_idx;
      pred_enable    = (state == S_IDLE);
      busy           = (state == S_INIT) || !fifo_empty;
      if (rst_n && !flush_req) begin
         if (state == S_INIT) begin
            tbl_we = 1'b1;
         end else if (!fifo_empty) begin
            tbl_we         = 1'b1;
            tbl_wr_index   = head_idx;
            tbl_wr_counter = ctr_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {upd_pc[INDEX_WIDTH-1:0], upd_taken};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         fifo_cnt  <= '0;
         upd_count <= '0;
      end else if (flush_req) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr    <= rd_ptr + 1'b1;
            upd_count <= upd_count + 16'd1;
         end
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Bench for bp_update_ctrl: a queue-based model checked every cycle, plus
// directed scenarios with hand-computed table writes.
module tb_bp_update_ctrl;
   localparam int IW = 4;
   localparam int AW = 26;
   localparam int D  = 4;
   localparam int N  = 16;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          upd_valid = 1'b0, upd_taken = 1'b0, flush_req = 1'b0;
   logic [AW-1:0] upd_pc = '0;
   logic          upd_ready, tbl_we, pred_enable, busy;
   logic [IW-1:0] tbl_rd_index, tbl_wr_index;
   logic [1:0]    tbl_rd_counter, tbl_wr_counter;
   logic [15:0]   upd_count;

   bp_update_ctrl #(.INDEX_WIDTH(IW), .ADDR_WIDTH(AW), .FIFO_DEPTH(D), .INIT_VALUE(2'b10)) dut (
      .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_ready(upd_ready),
      .upd_pc(upd_pc), .upd_taken(upd_taken), .flush_req(flush_req),
      .tbl_rd_index(tbl_rd_index), .tbl_rd_counter(tbl_rd_counter),
      .tbl_we(tbl_we), .tbl_wr_index(tbl_wr_index), .tbl_wr_counter(tbl_wr_counter),
      .pred_enable(pred_enable), .busy(busy), .upd_count(upd_count));

   always #5 clk = ~clk;

   // Counter table the block drives
   logic [1:0] tbl [N];
   assign tbl_rd_counter = tbl[tbl_rd_index];
   always @(posedge clk) if (tbl_we) tbl[tbl_wr_index] <= tbl_wr_counter;

   int pass_cnt = 0, chk_cnt = 0;

   task automatic chk(input string name, input int got, input int exp);
      chk_cnt++;
      if (got == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   // Model: a phase flag, a sweep position, a queue of pending updates, a table copy.
   bit m_init;
   int m_sweep, m_cnt;
   int m_q[$];
   int m_tbl[N];
   int wlog_idx[$], wlog_val[$];
   int e_we, e_idx, e_val, e_rdy, e_ent;

   function automatic int bump(input int c, input int t);
      if (t != 0) return (c + 1 > 3) ? 3 : c + 1;
      return (c - 1 < 0) ? 0 : c - 1;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_we", int'(tbl_we), 0);
         chk("rst_ready", int'(upd_ready), 0);
         chk("rst_pred", int'(pred_enable), 0);
         chk("rst_busy", int'(busy), 1);
         chk("rst_count", int'(upd_count), 0);
         m_init = 1; m_sweep = 0; m_cnt = 0; m_q.delete();
      end else begin
         e_rdy = (m_q.size() < D && !flush_req) ? 1 : 0;
         e_we = 0; e_idx = 0; e_val = 0;
         if (!flush_req) begin
            if (m_init) begin
               e_we = 1; e_idx = m_sweep; e_val = 2;
            end else if (m_q.size() > 0) begin
               e_we = 1; e_idx = m_q[0] / 2; e_val = bump(m_tbl[e_idx], m_q[0] % 2);
            end
         end
         chk("we", int'(tbl_we), e_we);
         chk("ready", int'(upd_ready), e_rdy);
         chk("pred", int'(pred_enable), m_init ? 0 : 1);
         chk("busy", int'(busy), (m_init || m_q.size() > 0) ? 1 : 0);
         chk("count", int'(upd_count), m_cnt);
         if (e_we != 0 && tbl_we) begin
            chk("wr_idx", int'(tbl_wr_index), e_idx);
            chk("wr_val", int'(tbl_wr_counter), e_val);
         end
         if (m_q.size() > 0) chk("rd_idx", int'(tbl_rd_index), m_q[0] / 2);
         if (tbl_we) begin
            wlog_idx.push_back(int'(tbl_wr_index));
            wlog_val.push_back(int'(tbl_wr_counter));
         end
         if (flush_req) begin
            m_init = 1; m_sweep = 0; m_q.delete();
         end else begin
            if (e_we != 0) m_tbl[e_idx] = e_val;
            if (m_init) begin
               m_sweep++;
               if (m_sweep == N) begin m_init = 0; m_sweep = 0; end
            end else if (m_q.size() > 0) begin
               e_ent = m_q.pop_front();
               m_cnt = (m_cnt + 1) % 65536;
            end
            if (upd_valid && e_rdy != 0)
               m_q.push_back(int'(upd_pc[IW-1:0]) * 2 + int'(upd_taken));
         end
      end
   end

   task automatic align(); @(posedge clk); #1; endtask
   task automatic settle(); @(negedge clk); #1; endtask
   task automatic idle(input int n); repeat (n) @(posedge clk); #1; endtask
   task automatic clr(); wlog_idx.delete(); wlog_val.delete(); endtask
   task automatic push(input int pc, input bit t);
      upd_valid = 1'b1; upd_pc = AW'(pc); upd_taken = t;
      @(posedge clk); #1 upd_valid = 1'b0;
   endtask
   task automatic chk_log(input string name, input int k, input int idx, input int val);
      if (wlog_idx.size() > k) begin
         chk({name, "_idx"}, wlog_idx[k], idx);
         chk({name, "_val"}, wlog_val[k], val);
      end else chk({name, "_missing"}, wlog_idx.size(), k + 1);
   endtask

   int errs;
   bit rdy_seen [5];
   int exp_rdy [5] = '{1, 1, 1, 1, 0};
   int pcs [5] = '{1, 2, 3, 4, 6};
   bit tks [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      clr();
      // Reset release: 16 sweep writes of 10, then predictions enabled
      idle(16); settle();
      chk("sweep_len", wlog_idx.size(), 16);
      errs = 0;
      for (int i = 0; i < 16 && i < wlog_idx.size(); i++)
         if (wlog_idx[i] != i || wlog_val[i] != 2) errs++;
      chk("sweep_vals", errs, 0);
      chk("pred_after_sweep", int'(pred_enable), 1);
      chk("count_after_sweep", int'(upd_count), 0);
      align();

      // Taken twice on index 5 (10 -> 11 -> 11); upper PC bits ignored
      clr(); push('h3ff0105, 1); push(5, 1); idle(3); settle();
      chk_log("t21a", 0, 5, 3); chk_log("t21b", 1, 5, 3);
      chk("t21_count", int'(upd_count), 2);
      align();

      // Saturation at both ends
      clr(); push(9, 0); push(9, 0); push(9, 0); push(5, 1); idle(3); settle();
      chk_log("t22a", 0, 9, 1); chk_log("t22b", 1, 9, 0);
      chk_log("t22c", 2, 9, 0); chk_log("t22d", 3, 5, 3);
      chk("t22_count", int'(upd_count), 6);
      align();

      // Back-to-back on one index starting from 01
      push(9, 1); idle(2);
      clr(); push(9, 1); push(9, 1); idle(3); settle();
      chk_log("t25a", 0, 9, 2); chk_log("t25b", 1, 9, 3);
      chk("t25_count", int'(upd_count), 9);
      align();

      // Flush with a concurrent offer, then 5 offers during the sweep
      flush_req = 1'b1; upd_valid = 1'b1; upd_pc = AW'(7); upd_taken = 1'b1;
      @(posedge clk); #1 flush_req = 1'b0; upd_valid = 1'b0;
      clr();
      for (int i = 0; i < 5; i++) begin
         upd_valid = 1'b1; upd_pc = AW'(pcs[i]); upd_taken = tks[i];
         @(negedge clk); rdy_seen[i] = upd_ready;
         @(posedge clk); #1;
      end
      upd_valid = 1'b0;
      for (int i = 0; i < 5; i++) chk("t23_ready", int'(rdy_seen[i]), exp_rdy[i]);
      begin : wait_idle
         bit done;
         done = 0;
         for (int k = 0; k < 40 && !done; k++) begin
            settle();
            if (!busy) done = 1;
         end
         chk("t23_busy_timeout", int'(done), 1);
      end
      chk("t23_len", wlog_idx.size(), 20);
      chk_log("t23a", 16, 1, 3); chk_log("t23b", 17, 2, 1);
      chk_log("t23c", 18, 3, 3); chk_log("t23d", 19, 4, 1);
      chk("t23_count", int'(upd_count), 13);
      align();

      // Flush at sweep index 7 with two entries queued
      flush_req = 1'b1; @(posedge clk); #1 flush_req = 1'b0;
      clr();
      push(10, 1); push(11, 0); idle(5);
      flush_req = 1'b1; upd_valid = 1'b1; upd_pc = AW'(12); upd_taken = 1'b1;
      settle();
      chk("t24_writes_before", wlog_idx.size(), 7);
      chk("t24_no_write", int'(tbl_we), 0);
      chk("t24_ready", int'(upd_ready), 0);
      @(posedge clk); #1 flush_req = 1'b0; upd_valid = 1'b0;
      clr(); errs = 0;
      for (int i = 0; i < 16; i++) begin
         settle();
         if (pred_enable) errs++;
      end
      chk("t24_pred_low", errs, 0);
      settle();
      chk("t24_pred_up", int'(pred_enable), 1);
      chk("t24_len", wlog_idx.size(), 16);
      chk_log("t24_first", 0, 0, 2);
      chk("t24_busy", int'(busy), 0);
      chk("t24_count", int'(upd_count), 13);
      align();

      // Asynchronous reset in the middle of a drain
      push(1, 0); push(2, 0); push(3, 1);
      rst_n = 1'b0;
      #1;
      chk("ar_we", int'(tbl_we), 0);
      chk("ar_busy", int'(busy), 1);
      chk("ar_pred", int'(pred_enable), 0);
      chk("ar_count", int'(upd_count), 0);
      chk("ar_ready", int'(upd_ready), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(16); settle();
      chk("ar_busy_after", int'(busy), 0);
      chk("ar_pred_after", int'(pred_enable), 1);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
